user_button_debounce: RTL and testbench

Input-side companion to the user LED driver on the Cyclone 10 GX board. It takes the raw, asynchronous, bouncing, active-low user pushbuttons and synchronises them to OSC_50m. It then debounces each channel and presents a clean, active-high level per button, plus single-cycle press, release and long-press event pulses for downstream logic such as LED pattern control.

---
 rtl/user_button_debounce_if.sv | 27 ++
 rtl/user_button_debounce.sv | 141 ++++++++++++++
 tb/tb_user_button_debounce.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_button_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : user_button_debounce_if
//  Description : Pushbutton pin and debounced event bundle between the board
//                pins/consumer (master) and the debounce block (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface user_button_debounce_if #(
   parameter int BTN_W = 4
);
   logic [BTN_W-1:0] USER_PB;      // raw pins, active-low
   logic [BTN_W-1:0] btn_level;    // debounced level, 1 = pressed
   logic [BTN_W-1:0] btn_press;    // one-cycle rise pulse
   logic [BTN_W-1:0] btn_release;  // one-cycle fall pulse
   logic [BTN_W-1:0] btn_long;     // one-cycle long-press pulse

   modport master (
      output USER_PB,
      input  btn_level, btn_press, btn_release, btn_long
   );

   modport slave (
      input  USER_PB,
      output btn_level, btn_press, btn_release, btn_long
   );
endinterface
`default_nettype wire

// File: rtl/user_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : user_button_debounce
//  Description : Synchronises active-low pushbuttons to OSC_50m, debounces
//                each channel and emits press / release / long-press pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module user_button_debounce #(
   parameter int BTN_W    = 4,
   parameter int DB_CYC   = 1000000,
   parameter int LONG_CYC = 50000000
) (
   input  wire                   OSC_50m,
   input  wire                   FPGA_RSTn,
   user_button_debounce_if.slave bus
);

   localparam int DB_W   = $clog2(DB_CYC + 1);
   localparam int HOLD_W = $clog2(LONG_CYC + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

   // Bit 0 is the debounced level, bit 1 the long-press-fired flag, so both
   // come straight off state flops.
   localparam logic [1:0] ST_RELEASED = 2'b00;
   localparam logic [1:0] ST_PRESSED  = 2'b01;
   localparam logic [1:0] ST_HELD     = 2'b11;

   logic             rst_meta;
   logic             rst_sync;
   logic [BTN_W-1:0] pb_meta;
   logic [BTN_W-1:0] pb_sync;
   logic [BTN_W-1:0] level;
   logic [BTN_W-1:0] press_q;
   logic [BTN_W-1:0] rel_q;
   logic [BTN_W-1:0] long_q;

   // Reset synchroniser: asynchronous assertion, deassertion aligned to the clock
   always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
      if (!FPGA_RSTn) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   // Two-flop pin synchroniser, parked at "released" (pin high) in reset
   always_ff @(posedge OSC_50m or negedge rst_sync) begin
      if (!rst_sync) begin
         pb_meta <= '1;
         pb_sync <= '1;
      end else begin
         pb_meta <= bus.USER_PB;
         pb_sync <= pb_meta;
      end
   end

   generate
      for (genvar i = 0; i < BTN_W; i++) begin : g_ch
         logic [1:0]        state;
         logic [1:0]        state_nxt;
         logic [DB_W-1:0]   db_cnt;
         logic [HOLD_W-1:0] hold_cnt;
         logic              s;
         logic              lvl;
         logic              lf;
         logic              differ;
         logic              accept;
         logic              long_hit;

         assign s = ~pb_sync[i];

         // State register
         always_ff @(posedge OSC_50m or negedge rst_sync) begin
            if (!rst_sync) state <= ST_RELEASED;
            else           state <= state_nxt;
         end

         // Channel events: a new level is accepted on the DB_CYC-th disagreeing cycle
         always_comb begin
            differ   = (s != lvl);
            accept   = differ && (db_cnt == DB_LAST);
            long_hit = lvl && !lf && (hold_cnt == HOLD_LAST);
         end

         // Next-state logic; an accepted release overrides a same-cycle long press
         always_comb begin
            state_nxt = state;
            case (state)
               ST_RELEASED: if (accept) state_nxt = ST_PRESSED;
               ST_PRESSED: begin
                  if (accept)        state_nxt = ST_RELEASED;
                  else if (long_hit) state_nxt = ST_HELD;
               end
               ST_HELD:     if (accept) state_nxt = ST_RELEASED;
               default:     state_nxt = ST_RELEASED;
            endcase
         end

         // Output decode of the state flops
         always_comb begin
            lvl = state[0];
            lf  = state[1];
         end

         // Debounce and hold counters plus registered event pulses
         always_ff @(posedge OSC_50m or negedge rst_sync) begin
            if (!rst_sync) begin
               db_cnt     <= '0;
               hold_cnt   <= '0;
               press_q[i] <= 1'b0;
               rel_q[i]   <= 1'b0;
               long_q[i]  <= 1'b0;
            end else begin
               if (!differ || accept) db_cnt <= '0;
               else                   db_cnt <= db_cnt + DB_W'(1);

               // Hold counter saturates at HOLD_LAST once the long press fires
               if (!lvl)                  hold_cnt <= '0;
               else if (!lf && !long_hit) hold_cnt <= hold_cnt + HOLD_W'(1);

               press_q[i] <= accept && s;
               rel_q[i]   <= accept && !s;
               long_q[i]  <= long_hit;
            end
         end

         assign level[i] = lvl;
      end
   endgenerate

   assign bus.btn_level   = level;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = rel_q;
   assign bus.btn_long    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_user_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_button_debounce
//  Description : Scoreboard bench for user_button_debounce with a behavioural
//                reference model, directed scenarios and random pin activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_user_button_debounce;

   localparam int BTN_W    = 4;
   localparam int DB_CYC   = 4;
   localparam int LONG_CYC = 10;
   localparam int LAT      = DB_CYC + 2;

   typedef struct {
      int               cyc;
      logic [BTN_W-1:0] p;
      logic [BTN_W-1:0] r;
      logic [BTN_W-1:0] l;
   } ev_t;

   logic clk     = 1'b0;
   logic rst_pin = 1'b0;
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   user_button_debounce_if #(.BTN_W(BTN_W)) bus ();

   user_button_debounce #(
      .BTN_W    (BTN_W),
      .DB_CYC   (DB_CYC),
      .LONG_CYC (LONG_CYC)
   ) dut (
      .OSC_50m   (clk),
      .FPGA_RSTn (rst_pin),
      .bus       (bus)
   );

   always #10 clk = ~clk;

   // Edge counter: after posedge number N, cyc reads N
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   ev_t               q[$];
   logic              m_rmeta = 1'b0;
   logic              m_rsync = 1'b0;
   logic [BTN_W-1:0]  m_syn1  = '1;
   logic [BTN_W-1:0]  m_syn2  = '1;
   logic [BTN_W-1:0]  m_lvl   = '0;
   logic [BTN_W-1:0]  m_fired = '0;
   logic [DB_CYC-1:0] m_win  [BTN_W];
   int                m_nwin [BTN_W];
   int                m_rise [BTN_W];
   logic [BTN_W-1:0]  m_ep, m_er, m_el;
   logic              m_s, m_acc;
   int                m_e;

   task automatic m_clear_chans();
      m_syn1  = '1;
      m_syn2  = '1;
      m_lvl   = '0;
      m_fired = '0;
      for (int i = 0; i < BTN_W; i++) begin
         m_win[i]  = '0;
         m_nwin[i] = 0;
         m_rise[i] = 0;
      end
   endtask

   always @(posedge clk or negedge rst_pin) begin
      if (!rst_pin) begin
         m_rmeta = 1'b0;
         m_rsync = 1'b0;
         m_clear_chans();
      end else begin
         m_e = cyc + 1;
         if (!m_rsync) begin
            m_clear_chans();
         end else begin
            m_ep = '0; m_er = '0; m_el = '0;
            for (int i = 0; i < BTN_W; i++) begin
               m_s = ~m_syn2[i];
               // Long press: level has been high for LONG_CYC edges since its rise
               if (m_lvl[i] && !m_fired[i] && (m_e - m_rise[i] == LONG_CYC)) begin
                  m_el[i]    = 1'b1;
                  m_fired[i] = 1'b1;
               end
               // Accept a new level once the last DB_CYC samples all disagree
               m_win[i] = {m_win[i][DB_CYC-2:0], m_s};
               if (m_nwin[i] < DB_CYC) m_nwin[i]++;
               m_acc = (m_nwin[i] >= DB_CYC) && (m_win[i] == {DB_CYC{~m_lvl[i]}});
               if (m_acc) begin
                  m_lvl[i]  = m_s;
                  m_nwin[i] = 0;
                  if (m_s) begin
                     m_ep[i]    = 1'b1;
                     m_rise[i]  = m_e;
                     m_fired[i] = 1'b0;
                  end else begin
                     m_er[i] = 1'b1;
                  end
               end
            end
            if ((m_ep | m_er | m_el) != '0) q.push_back('{m_e, m_ep, m_er, m_el});
            m_syn2 = m_syn1;
            m_syn1 = bus.USER_PB;
         end
         m_rsync = m_rmeta;
         m_rmeta = 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int press_cnt [BTN_W];
   int rel_cnt   [BTN_W];
   int long_cnt  [BTN_W];
   int last_press[BTN_W];
   int last_rel  [BTN_W];
   int last_long [BTN_W];
   ev_t ev;

   initial begin
      for (int i = 0; i < BTN_W; i++) begin
         press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
         last_press[i] = -1; last_rel[i] = -1; last_long[i] = -1;
      end
   end

   always @(negedge clk) begin
      n_checks++;
      if (bus.btn_level !== m_lvl) begin
         n_fail++;
         $display("FAIL level @%0d: got %h expected %h", cyc, bus.btn_level, m_lvl);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
         ev = q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_event @%0d: p=%h r=%h l=%h never seen", ev.cyc, ev.p, ev.r, ev.l);
      end
      if ((bus.btn_press | bus.btn_release | bus.btn_long) != '0 ||
          (q.size() > 0 && q[0].cyc == cyc)) begin
         n_checks++;
         if (q.size() == 0 || q[0].cyc != cyc) begin
            n_fail++;
            $display("FAIL unexpected_event @%0d: got p=%h r=%h l=%h expected none",
                     cyc, bus.btn_press, bus.btn_release, bus.btn_long);
         end else begin
            ev = q.pop_front();
            if (bus.btn_press !== ev.p || bus.btn_release !== ev.r || bus.btn_long !== ev.l) begin
               n_fail++;
               $display("FAIL event @%0d: got p=%h r=%h l=%h expected p=%h r=%h l=%h",
                        cyc, bus.btn_press, bus.btn_release, bus.btn_long, ev.p, ev.r, ev.l);
            end
         end
         for (int i = 0; i < BTN_W; i++) begin
            if (bus.btn_press[i] === 1'b1)   begin press_cnt[i]++; last_press[i] = cyc; end
            if (bus.btn_release[i] === 1'b1) begin rel_cnt[i]++;   last_rel[i]   = cyc; end
            if (bus.btn_long[i] === 1'b1)    begin long_cnt[i]++;  last_long[i]  = cyc; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int k;
   int base;
   int flip_div;

   initial begin
      bus.USER_PB = '1;
      rst_pin     = 1'b0;
      tick(5);
      rst_pin = 1'b1;
      tick(50);

      // Clean press and release on channel 0
      k = cyc; bus.USER_PB[0] = 1'b0;
      tick(8);
      check("press0_latency", last_press[0] - k, LAT);
      k = cyc; bus.USER_PB[0] = 1'b1;
      tick(10);
      check("release0_latency", last_rel[0] - k, LAT);
      tick(10);

      // Bounce rejection on channel 1: lows of 3, 2, 3 cycles then hold low
      base = press_cnt[1];
      bus.USER_PB[1] = 1'b0; tick(3); bus.USER_PB[1] = 1'b1; tick(2);
      bus.USER_PB[1] = 1'b0; tick(2); bus.USER_PB[1] = 1'b1; tick(2);
      bus.USER_PB[1] = 1'b0; tick(3); bus.USER_PB[1] = 1'b1; tick(2);
      k = cyc; bus.USER_PB[1] = 1'b0;
      tick(9);
      check("bounce1_press_count", press_cnt[1] - base, 1);
      check("bounce1_latency", last_press[1] - k, LAT);
      bus.USER_PB[1] = 1'b1;
      tick(30);

      // Long press on channel 2, twice
      base = long_cnt[2];
      bus.USER_PB[2] = 1'b0;
      tick(40);
      check("long2_delay", last_long[2] - last_press[2], LONG_CYC);
      check("long2_once", long_cnt[2] - base, 1);
      bus.USER_PB[2] = 1'b1;
      tick(20);
      bus.USER_PB[2] = 1'b0;
      tick(30);
      check("long2_second", long_cnt[2] - base, 2);
      bus.USER_PB[2] = 1'b1;
      tick(20);

      // All channels pressed in the same cycle
      k = cyc; bus.USER_PB = '0;
      tick(20);
      for (int i = 0; i < BTN_W; i++) check("simul_press", last_press[i] - k, LAT);
      bus.USER_PB = '1;
      tick(30);

      // Reset while channel 3 is held past its long press
      bus.USER_PB[3] = 1'b0;
      tick(25);
      base = rel_cnt[3];
      #2 rst_pin = 1'b0;
      #1 check("async_clear", int'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long}), 0);
      tick(3);
      k = cyc; rst_pin = 1'b1;
      base = press_cnt[3];
      tick(12);
      check("reset3_press_count", press_cnt[3] - base, 1);
      check("reset3_latency", last_press[3] - k, LAT + 2);
      bus.USER_PB[3] = 1'b1;
      tick(30);

      // Random pin activity with occasional resets
      flip_div = 8;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (n % 300 == 0) flip_div = $urandom_range(2, 24);
         for (int c = 0; c < BTN_W; c++)
            if ($urandom_range(0, flip_div - 1) == 0) bus.USER_PB[c] = ~bus.USER_PB[c];
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_pin = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst_pin = 1'b1;
         end
      end
      bus.USER_PB = '1;
      tick(40);
      check("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
